svetofor_intersection: RTL and testbench
========================================

Name: svetofor_intersection

Overview:
- Parametrised successor of the single three-LED stoplight block.
- Drives N_APPR approaches, each with its own red, yellow and green lamps, in a round-robin intersection sequence. Adds an all-red clearance phase, a red+yellow prepare phase, a night flashing-yellow mode and, optionally, pedestrian-request green truncation.
- Clocked by the half-second time tick: 1 cycle = 0.5 s. Sits directly under the board top, next to the tick divider.

Parameters:
- N_APPR, 2: number of approaches. Legal range 2..4.
- TW, 8: timer width. Every duration below must be ≥1 and < 2^TW.
- ALLRED_T, 4: all-red clearance phase, in ticks.
- REDYEL_T, 4: red+yellow prepare phase, in ticks.
- GREEN_T, 52: steady green phase, in ticks.
- BLNK_T, 8: blinking green phase, in ticks. Must be even.
- YELLOW_T, 6: yellow phase, in ticks.
- NIGHT_HALF, 2: night-mode half-period of the yellow flash, in ticks.
- MIN_GREEN, 20: minimum steady green before a pedestrian truncation. Used only with PED_REQ_EN. Must be ≤ GREEN_T.

Ports:
- time_signal  in  1  clock (half-second tick)
- reset  in  1  synchronous, active-high reset
- night  in  1  night-mode request, level-sensitive, synchronous to time_signal
- red  out  N_APPR  red lamp per approach
- yellow  out  N_APPR  yellow lamp per approach
- green  out  N_APPR  green lamp per approach
- active_idx  out  2  approach currently owning the right of way
- phase  out  3  current state encoding
- ped_req  in  N_APPR  pedestrian buttons, one per approach (present only with PED_REQ_EN)

Behaviour:
- Reset (synchronous, active-high):
  - state=ALL_RED, timer=0, active_idx=N_APPR-1, so approach 0 is served first.
  - red = all ones; yellow and green = all zeros.
  - Reset asserted mid-sequence forces this state on the next edge.
- Outputs: all registered, no combinational path from inputs.
- Phase encodings: ALL_RED=0, RED_YEL=1, GREEN=2, BLINK=3, YELLOW=4, NIGHT=5.
- Timer rule: timer counts 0..T-1 within a state. The state exits when timer==T-1, so each state lasts exactly T cycles. Timer resets to 0 on every transition.
- Sequence:
  - ALL_RED → RED_YEL, with active_idx advanced: idx+1, wrapping at N_APPR-1 → 0.
  - RED_YEL → GREEN → BLINK → YELLOW → ALL_RED.
- Lamps per state. Non-active approaches always show red only. The active approach shows:
  - ALL_RED: red.
  - RED_YEL: red+yellow.
  - GREEN: green.
  - BLINK: green = ~timer[0] (on at even timer values), red and yellow off.
  - YELLOW: yellow.
  - NIGHT: every approach red=0, green=0, yellow=flash.
- Safety invariant: at most one approach has green=1 or yellow=1 in any cycle, except in NIGHT.
- Night entry:
  - `night` is sampled only on the last cycle of ALL_RED.
  - If night=1 there, next state is NIGHT instead of RED_YEL, and active_idx is unchanged.
  - night asserted in any other state has no effect until that point.
- NIGHT:
  - flash starts at 1 and toggles every NIGHT_HALF ticks. The timer counts to NIGHT_HALF-1 and wraps.
  - night=0 sampled in any NIGHT cycle → ALL_RED next, timer=0, lamps all-red.
- Full cycle with defaults: 74 ticks per approach, 148 ticks for N_APPR=2.

Optional Feature:
- Macro: SVETOFOR_PED_REQ_EN.
- With the macro defined:
  - ped_req bits are latched into a sticky ped_pend[N_APPR-1:0].
  - In GREEN, if any ped_pend bit other than active_idx is set and timer ≥ MIN_GREEN-1, the next state is BLINK.
  - ped_pend[i] clears on entry to RED_YEL for approach i.
  - ped_req[i] asserted in the same cycle as that clear keeps the bit set (set wins).
  - Reset clears ped_pend.
- Without the macro: the ped_req port is absent and GREEN always lasts GREEN_T.

Decomposition:
- Package svetofor_pkg holds:
  - the phase enum/localparams (ALL_RED..NIGHT);
  - a lamp-triple struct {red, yellow, green};
  - a function for modulo-N index increment.
- One sub-module, svetofor_phase_timer: a TW-bit counter with clear and terminal-count (==T-1) output, reused for phase and night-flash timing.

Test Plan:
- Reset release, defaults, N_APPR=2:
  - cycles 0–3: all red;
  - cycles 4–7: approach 0 red+yellow;
  - cycles 8–59: green0;
  - cycles 60–67: green0 toggling 1,0,1,0…;
  - cycles 68–73: yellow0;
  - cycle 78: approach 1 in RED_YEL.
- Run 3 full cycles with N_APPR=4 → active_idx sequence 0,1,2,3,0,1,2,3,0,1,2,3. Per-cycle checker: never two approaches with green|yellow.
- night=1 asserted during GREEN of approach 0:
  - lamps finish BLINK, YELLOW and ALL_RED unchanged;
  - then all yellow flash 1,1,0,0,…;
  - night=0 → 4 all-red ticks, then approach 1 RED_YEL.
- reset=1 pulsed at timer=30 of GREEN → next cycle red=all ones, phase=0, active_idx=N_APPR-1.
- With SVETOFOR_PED_REQ_EN, ped_req[1] pulsed at GREEN timer=5 of approach 0:
  - BLINK starts at GREEN timer 20 (MIN_GREEN);
  - ped_pend[1] clears when approach 1 enters RED_YEL.
- With SVETOFOR_PED_REQ_EN, ped_req[0] pulsed during approach 0 GREEN → no truncation; ped_pend[0] clears at approach 0's next RED_YEL.

Source files
------------

// File: rtl/svetofor_pkg.sv
// Shared types for the multi-approach stoplight: phase encoding, lamp triple
// and the round-robin index step.
package svetofor_pkg;

  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    RED_YEL = 3'd1,
    GREEN   = 3'd2,
    BLINK   = 3'd3,
    YELLOW  = 3'd4,
    NIGHT   = 3'd5
  } phase_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_OFF = '{red: 1'b0, yellow: 1'b0, green: 1'b0};
  localparam lamp_t LAMP_RED = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
  localparam lamp_t LAMP_RY  = '{red: 1'b1, yellow: 1'b1, green: 1'b0};
  localparam lamp_t LAMP_YEL = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
  localparam lamp_t LAMP_GRN = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

  // Next approach in round-robin order, wrapping at n-1.
  function automatic logic [1:0] idx_inc(input logic [1:0] idx, input int n);
    if (int'(idx) >= n - 1) return 2'd0;
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/svetofor_if.sv
// Lamp/phase bundle between the intersection controller and the board top.
// Carries ped_req only when SVETOFOR_PED_REQ_EN is defined.
interface svetofor_if #(parameter int N_APPR = 2);
  logic              night;
  logic [N_APPR-1:0] red;
  logic [N_APPR-1:0] yellow;
  logic [N_APPR-1:0] green;
  logic [1:0]        active_idx;
  logic [2:0]        phase;
`ifdef SVETOFOR_PED_REQ_EN
  logic [N_APPR-1:0] ped_req;

  modport master (input night, input ped_req,
                  output red, output yellow, output green,
                  output active_idx, output phase);
  modport slave  (output night, output ped_req,
                  input red, input yellow, input green,
                  input active_idx, input phase);
`else
  modport master (input night,
                  output red, output yellow, output green,
                  output active_idx, output phase);
  modport slave  (output night,
                  input red, input yellow, input green,
                  input active_idx, input phase);
`endif
endinterface

// File: rtl/svetofor_phase_timer.sv
// Free-running TW-bit tick counter with synchronous clear and a terminal-count
// flag at cnt == lim; shared by phase durations and night-flash half-periods.
module svetofor_phase_timer #(
  parameter int TW = 8
) (
  input  logic          time_signal,
  input  logic          reset,
  input  logic          clr,
  input  logic [TW-1:0] lim,
  output logic [TW-1:0] cnt,
  output logic          tc
);

  always_ff @(posedge time_signal) begin
    if (reset || clr) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == lim);

endmodule

// File: rtl/svetofor_intersection.sv
// Round-robin N_APPR-approach stoplight with all-red clearance, red+yellow
// prepare, blinking green and night flash. Optional SVETOFOR_PED_REQ_EN.
module svetofor_intersection #(
  parameter int N_APPR     = 2,
  parameter int TW         = 8,
  parameter int ALLRED_T   = 4,
  parameter int REDYEL_T   = 4,
  parameter int GREEN_T    = 52,
  parameter int BLNK_T     = 8,
  parameter int YELLOW_T   = 6,
  parameter int NIGHT_HALF = 2,
  parameter int MIN_GREEN  = 20
) (
  input  logic       time_signal,
  input  logic       reset,
  svetofor_if.master bus
);
  import svetofor_pkg::*;

  phase_e                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic                     flash_q, flash_d;
  lamp_t [N_APPR-1:0]       lamp_q, lamp_d;
  logic [TW-1:0]            lim, cnt, timer_d;
  logic                     tc, clr, ped_cut;

  always_comb begin
    case (state_q)
      ALL_RED: lim = TW'(ALLRED_T - 1);
      RED_YEL: lim = TW'(REDYEL_T - 1);
      GREEN:   lim = TW'(GREEN_T - 1);
      BLINK:   lim = TW'(BLNK_T - 1);
      YELLOW:  lim = TW'(YELLOW_T - 1);
      default: lim = TW'(NIGHT_HALF - 1);
    endcase
  end

  svetofor_phase_timer #(.TW(TW)) u_timer (
    .time_signal (time_signal),
    .reset       (reset),
    .clr         (clr),
    .lim         (lim),
    .cnt         (cnt),
    .tc          (tc)
  );

`ifdef SVETOFOR_PED_REQ_EN
  logic [N_APPR-1:0] ped_pend, pend_clr;

  // Only a waiting request from another approach may cut the current green.
  assign ped_cut  = (|(ped_pend & ~(N_APPR'(1) << idx_q))) && (cnt >= TW'(MIN_GREEN - 1));
  assign pend_clr = (state_d == RED_YEL && state_q != RED_YEL) ? (N_APPR'(1) << idx_d) : '0;

  always_ff @(posedge time_signal) begin
    if (reset) ped_pend <= '0;
    else       ped_pend <= (ped_pend & ~pend_clr) | bus.ped_req;
  end
`else
  assign ped_cut = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    flash_d = flash_q;
    case (state_q)
      ALL_RED: if (tc) begin
        if (bus.night) begin
          state_d = NIGHT;
          flash_d = 1'b1;
        end else begin
          state_d = RED_YEL;
          idx_d   = idx_inc(idx_q, N_APPR);
        end
      end
      RED_YEL: if (tc) state_d = GREEN;
      GREEN:   if (tc || ped_cut) state_d = BLINK;
      BLINK:   if (tc) state_d = YELLOW;
      YELLOW:  if (tc) state_d = ALL_RED;
      NIGHT: begin
        if (!bus.night) state_d = ALL_RED;
        else if (tc)    flash_d = ~flash_q;
      end
      default: state_d = ALL_RED;
    endcase
  end

  // Night timer wraps each half-period; otherwise it clears on phase change.
  assign clr     = (state_d != state_q) || (state_q == NIGHT && tc);
  assign timer_d = clr ? '0 : cnt + 1'b1;

  // Lamps decoded from next-state values so the outputs come straight off flops.
  always_comb begin
    lamp_d = {N_APPR{LAMP_RED}};
    for (int i = 0; i < N_APPR; i++) begin
      if (state_d == NIGHT) begin
        lamp_d[i] = flash_d ? LAMP_YEL : LAMP_OFF;
      end else if (idx_d == 2'(i)) begin
        case (state_d)
          RED_YEL: lamp_d[i] = LAMP_RY;
          GREEN:   lamp_d[i] = LAMP_GRN;
          BLINK:   lamp_d[i] = timer_d[0] ? LAMP_OFF : LAMP_GRN;
          YELLOW:  lamp_d[i] = LAMP_YEL;
          default: lamp_d[i] = LAMP_RED;
        endcase
      end
    end
  end

  always_ff @(posedge time_signal) begin
    if (reset) begin
      state_q <= ALL_RED;
      idx_q   <= 2'(N_APPR - 1);
      flash_q <= 1'b0;
      lamp_q  <= {N_APPR{LAMP_RED}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      flash_q <= flash_d;
      lamp_q  <= lamp_d;
    end
  end

  for (genvar g = 0; g < N_APPR; g++) begin : g_lamp
    assign bus.red[g]    = lamp_q[g].red;
    assign bus.yellow[g] = lamp_q[g].yellow;
    assign bus.green[g]  = lamp_q[g].green;
  end

  assign bus.active_idx = idx_q;
  assign bus.phase      = state_q;

endmodule

// File: tb/tb_svetofor_intersection.sv
// Directed bench: two-approach sequence, night, mid-run reset, four-approach
// round robin with safety check, and pedestrian truncation when enabled.
module tb_svetofor_intersection;

  logic time_signal = 1'b0;
  logic reset2 = 1'b1;
  logic reset4 = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;

  always #5 time_signal = ~time_signal;

  svetofor_if #(.N_APPR(2)) bus2 ();
  svetofor_if #(.N_APPR(4)) bus4 ();

  svetofor_intersection #(.N_APPR(2)) dut2 (
    .time_signal (time_signal),
    .reset       (reset2),
    .bus         (bus2)
  );

  svetofor_intersection #(.N_APPR(4)) dut4 (
    .time_signal (time_signal),
    .reset       (reset4),
    .bus         (bus4)
  );

  // {phase, active_idx, red, yellow, green}
  function automatic logic [10:0] obs2();
    return {bus2.phase, bus2.active_idx, bus2.red, bus2.yellow, bus2.green};
  endfunction

  // Hand-derived default-timing sequence for two approaches, cycles 0..78.
  function automatic logic [10:0] exp_seq(input int c);
    if (c < 4)  return {3'd0, 2'd1, 2'b11, 2'b00, 2'b00};
    if (c < 8)  return {3'd1, 2'd0, 2'b11, 2'b01, 2'b00};
    if (c < 60) return {3'd2, 2'd0, 2'b10, 2'b00, 2'b01};
    if (c < 68) return {3'd3, 2'd0, 2'b10, 2'b00, ((c - 60) % 2 == 0) ? 2'b01 : 2'b00};
    if (c < 74) return {3'd4, 2'd0, 2'b10, 2'b01, 2'b00};
    if (c < 78) return {3'd0, 2'd0, 2'b11, 2'b00, 2'b00};
    return {3'd1, 2'd1, 2'b11, 2'b10, 2'b00};
  endfunction

  task automatic tick();
    @(posedge time_signal);
    #1;
    cyc++;
  endtask

  task automatic reset_dut2();
    reset2 = 1'b1;
    @(posedge time_signal);
    #1;
    reset2 = 1'b0;
    cyc = 0;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic test_reset();
    reset_dut2();
    total_cnt++;
    if (obs2() !== {3'd0, 2'd1, 2'b11, 2'b00, 2'b00})
      $display("FAIL reset_state got=%h exp=%h", obs2(), {3'd0, 2'd1, 2'b11, 2'b00, 2'b00});
    else pass_cnt++;
  endtask

  task automatic test_sequence();
    reset_dut2();
    for (int c = 0; c <= 78; c++) begin
      tick_to(c);
      total_cnt++;
      if (obs2() !== exp_seq(c))
        $display("FAIL sequence cyc=%0d got=%h exp=%h", c, obs2(), exp_seq(c));
      else pass_cnt++;
    end
  endtask

  task automatic test_night();
    logic [10:0] e;
    reset_dut2();
    for (int c = 0; c <= 90; c++) begin
      tick_to(c);
      if (c == 20) bus2.night = 1'b1;
      if (c == 85) bus2.night = 1'b0;
      if (c <= 77)      e = exp_seq(c);
      else if (c <= 85) e = {3'd5, 2'd0, 2'b00, (((c - 78) / 2) % 2 == 0) ? 2'b11 : 2'b00, 2'b00};
      else if (c <= 89) e = {3'd0, 2'd0, 2'b11, 2'b00, 2'b00};
      else              e = {3'd1, 2'd1, 2'b11, 2'b10, 2'b00};
      total_cnt++;
      if (obs2() !== e) $display("FAIL night cyc=%0d got=%h exp=%h", c, obs2(), e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_green();
    reset_dut2();
    tick_to(38);
    total_cnt++;
    if (bus2.phase !== 3'd2) $display("FAIL pre_reset_phase got=%0d exp=2", bus2.phase);
    else pass_cnt++;
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    total_cnt++;
    if (obs2() !== {3'd0, 2'd1, 2'b11, 2'b00, 2'b00})
      $display("FAIL reset_mid_green got=%h exp=%h", obs2(), {3'd0, 2'd1, 2'b11, 2'b00, 2'b00});
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int entries = 0;
    logic [2:0] prev_phase = 3'd0;
    reset4 = 1'b1;
    @(posedge time_signal);
    #1;
    reset4 = 1'b0;
    for (int c = 0; c < 3 * 4 * 74; c++) begin
      if (c > 0) begin
        @(posedge time_signal);
        #1;
      end
      total_cnt++;
      if ($countones(bus4.green | bus4.yellow) > 1)
        $display("FAIL safety4 cyc=%0d got=g%b/y%b exp=at_most_one", c, bus4.green, bus4.yellow);
      else pass_cnt++;
      if (bus4.phase == 3'd1 && prev_phase != 3'd1) begin
        total_cnt++;
        if (bus4.active_idx !== 2'(entries % 4))
          $display("FAIL rr_idx entry=%0d got=%0d exp=%0d", entries, bus4.active_idx, entries % 4);
        else pass_cnt++;
        entries++;
      end
      prev_phase = bus4.phase;
    end
    total_cnt++;
    if (entries != 12) $display("FAIL rr_entries got=%0d exp=12", entries);
    else pass_cnt++;
  endtask

`ifdef SVETOFOR_PED_REQ_EN
  task automatic test_ped_truncate();
    reset_dut2();
    tick_to(13);
    bus2.ped_req = 2'b10;
    tick();
    bus2.ped_req = 2'b00;
    total_cnt++;
    if (dut2.ped_pend !== 2'b10) $display("FAIL ped_latch got=%b exp=10", dut2.ped_pend);
    else pass_cnt++;
    tick_to(27);
    total_cnt++;
    if (bus2.phase !== 3'd2) $display("FAIL ped_green_end got=%0d exp=2", bus2.phase);
    else pass_cnt++;
    tick_to(28);
    total_cnt++;
    if (obs2() !== {3'd3, 2'd0, 2'b10, 2'b00, 2'b01})
      $display("FAIL ped_blink_start got=%h exp=%h", obs2(), {3'd3, 2'd0, 2'b10, 2'b00, 2'b01});
    else pass_cnt++;
    tick_to(45);
    total_cnt++;
    if (dut2.ped_pend !== 2'b10) $display("FAIL ped_hold got=%b exp=10", dut2.ped_pend);
    else pass_cnt++;
    tick_to(46);
    total_cnt++;
    if ({bus2.phase, bus2.active_idx, dut2.ped_pend} !== {3'd1, 2'd1, 2'b00})
      $display("FAIL ped_clear got=%h exp=%h", {bus2.phase, bus2.active_idx, dut2.ped_pend}, {3'd1, 2'd1, 2'b00});
    else pass_cnt++;
  endtask

  task automatic test_ped_self();
    reset_dut2();
    tick_to(13);
    bus2.ped_req = 2'b01;
    tick();
    bus2.ped_req = 2'b00;
    tick_to(59);
    total_cnt++;
    if (bus2.phase !== 3'd2) $display("FAIL ped_self_no_cut got=%0d exp=2", bus2.phase);
    else pass_cnt++;
    tick_to(151);
    total_cnt++;
    if (dut2.ped_pend !== 2'b01) $display("FAIL ped_self_hold got=%b exp=01", dut2.ped_pend);
    else pass_cnt++;
    tick_to(152);
    total_cnt++;
    if ({bus2.phase, bus2.active_idx, dut2.ped_pend} !== {3'd1, 2'd0, 2'b00})
      $display("FAIL ped_self_clear got=%h exp=%h", {bus2.phase, bus2.active_idx, dut2.ped_pend}, {3'd1, 2'd0, 2'b00});
    else pass_cnt++;
  endtask
`endif

  initial begin
    bus2.night = 1'b0;
    bus4.night = 1'b0;
`ifdef SVETOFOR_PED_REQ_EN
    bus2.ped_req = '0;
    bus4.ped_req = '0;
`endif
    test_reset();
    test_sequence();
    test_night();
    test_reset_mid_green();
    test_round_robin();
`ifdef SVETOFOR_PED_REQ_EN
    test_ped_truncate();
    test_ped_self();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
